neuron_stream_driver: RTL and testbench

// Host-side driver for the semi-serial neuron datapath. Accepts one frame per result over a valid/ready

---
 rtl/neuron_stream_driver.sv | 165 ++++++++++++++++
 tb/tb_neuron_stream_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_stream_driver.sv
// Stream front-end for the free-running semi-serial neuron: collects an operand frame,
// holds it at the neuron across a flush pass plus one clean pass, then returns the result.
module neuron_stream_driver #(
  parameter int unsigned N       = 2,
  parameter int unsigned QM      = 12,
  parameter int unsigned QN      = 20,
  parameter int unsigned WM      = 6,
  parameter int unsigned WN      = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [QM+QN-1:0]      s_x,
  input  logic signed [WM+WN-1:0]      s_w,
  input  logic                         s_last,
  output logic [N-1:0][QM+QN-1:0]      nrn_in,
  output logic [N-1:0][WM+WN-1:0]      nrn_weights,
  output logic [QM+QN-1:0]             nrn_bias,
  input  logic [QM+QN-1:0]             nrn_out,
  input  logic                         nrn_done,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [QM+QN-1:0]             m_data,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned XW = QM + QN;
  localparam int unsigned WW = WM + WN;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_LOAD, S_ARM, S_WAIT, S_OUT} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TW-1:0]         tmr_q, tmr_d;
  logic [N-1:0][XW-1:0]  in_q, in_d;
  logic [N-1:0][WW-1:0]  w_q, w_d;
  logic [XW-1:0]         bias_q, bias_d;
  logic [XW-1:0]         mdata_q, mdata_d;
  logic                  mvalid_q, mvalid_d;
  logic                  sready_q, sready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic xfer;
  logic tmo;

  assign xfer = s_valid & sready_q;
  assign tmo  = (tmr_q == TW'(TIMEOUT - 1));

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      cnt_q    <= '0;
      tmr_q    <= '0;
      in_q     <= '0;
      w_q      <= '0;
      bias_q   <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      sready_q <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      in_q     <= in_d;
      w_q      <= w_d;
      bias_q   <= bias_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
      sready_q <= sready_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    in_d    = in_q;
    w_d     = w_q;
    bias_d  = bias_q;
    mdata_d = mdata_q;
    err_d   = err_q;

    case (state_q)
      S_LOAD: begin
        if (xfer) begin
          if (cnt_q == CW'(N)) begin
            bias_d  = s_x;
            cnt_d   = '0;
            tmr_d   = '0;
            state_d = S_ARM;
            if (!s_last) err_d = 1'b1;
          end else if (s_last) begin
            // Short frame: drop it, keep whatever operands already landed
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            for (int unsigned i = 0; i < N; i++) begin
              if (cnt_q == CW'(i)) begin
                in_d[i] = s_x;
                w_d[i]  = s_w;
              end
            end
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_ARM: begin
        // The pass in flight may have seen stale operands, so its result is thrown away
        if (nrn_done) begin
          tmr_d   = '0;
          state_d = S_WAIT;
        end else if (tmo) begin
          tmr_d   = '0;
          err_d   = 1'b1;
          state_d = S_LOAD;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_WAIT: begin
        if (nrn_done) begin
          mdata_d = nrn_out;
          tmr_d   = '0;
          state_d = S_OUT;
        end else if (tmo) begin
          tmr_d   = '0;
          err_d   = 1'b1;
          state_d = S_LOAD;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_OUT: begin
        if (mvalid_q && m_ready) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase

    sready_d = (state_d == S_LOAD);
    mvalid_d = (state_d == S_OUT);
    busy_d   = (state_d != S_LOAD);
  end

  assign s_ready     = sready_q;
  assign nrn_in      = in_q;
  assign nrn_weights = w_q;
  assign nrn_bias    = bias_q;
  assign m_valid     = mvalid_q;
  assign m_data      = mdata_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_neuron_stream_driver.sv
// Directed bench for neuron_stream_driver with a free-running behavioural neuron
// (fixed pass length, result from operands sampled at pass start, ReLU output).
module tb_neuron_stream_driver;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned PASS    = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_x;
  logic [15:0]       s_w;
  logic              s_last;
  logic [1:0][31:0]  nrn_in;
  logic [1:0][15:0]  nrn_weights;
  logic [31:0]       nrn_bias;
  logic [31:0]       nrn_out;
  logic              nrn_done;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_data;
  logic              busy;
  logic              err;

  int total = 0;
  int bad   = 0;

  neuron_stream_driver #(
    .N(2), .QM(12), .QN(20), .WM(6), .WN(10), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_w(s_w), .s_last(s_last),
    .nrn_in(nrn_in), .nrn_weights(nrn_weights), .nrn_bias(nrn_bias),
    .nrn_out(nrn_out), .nrn_done(nrn_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural neuron: Q12.20 x Q6.10 products rescaled to Q12.20, plus bias, ReLU
  function automatic logic [31:0] neuron(input logic [1:0][31:0] xi,
                                         input logic [1:0][15:0] wi,
                                         input logic [31:0] b);
    longint acc;
    acc = longint'($signed(b));
    for (int i = 0; i < 2; i++)
      acc = acc + ((longint'($signed(xi[i])) * longint'($signed(wi[i]))) >>> 10);
    if (acc < 0) return 32'h0;
    return 32'(acc);
  endfunction

  logic [2:0]  ph = 3'd0;
  logic [31:0] snap = 32'h0;
  logic        nrn_en = 1'b1;

  always @(posedge clk) begin
    ph <= (ph == 3'(PASS - 1)) ? 3'd0 : ph + 3'd1;
    if (ph == 3'(PASS - 1)) snap <= neuron(nrn_in, nrn_weights, nrn_bias);
  end
  assign nrn_done = nrn_en && (ph == 3'(PASS - 1));
  assign nrn_out  = snap;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_beat(input logic [31:0] x, input logic [15:0] w, input logic last);
    @(negedge clk);
    s_valid = 1'b1; s_x = x; s_w = w; s_last = last;
    for (int i = 0; i < 50 && !s_ready; i++) @(negedge clk);
    if (!s_ready) chk("s_ready_wait", 64'(s_ready), 64'd1);
    @(posedge clk);
    #1 s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_case1();
    send_beat(32'h0010_0000, 16'h0200, 1'b0);
    send_beat(32'h0020_0000, 16'h0100, 1'b0);
    send_beat(32'h0004_0000, 16'h0000, 1'b1);
  endtask

  task automatic wait_result(input string tag, input logic [31:0] exp);
    int dones = 0;
    bit found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_valid) begin found = 1; break; end
      if (nrn_done) dones++;
    end
    chk({tag, "_mvalid"}, 64'(found), 64'd1);
    chk({tag, "_data"}, 64'(m_data), 64'(exp));
    chk({tag, "_passes"}, 64'(dones), 64'd2);
  endtask

  task automatic handshake(input string tag);
    m_ready = 1'b1;
    @(posedge clk);
    #1 m_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_hs"}, {61'd0, m_valid, s_ready, busy}, 64'b010);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; nrn_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int mv_seen;
    int held;
    rst_n = 1'b0; s_valid = 1'b0; s_x = '0; s_w = '0; s_last = 1'b0; m_ready = 1'b0;

    // Reset state
    #1;
    chk("rst_ops", {nrn_in, nrn_weights[0], nrn_bias}, 64'd0);
    chk("rst_flags", {59'd0, s_ready, m_valid, busy, err, |m_data}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sready_after", 64'(s_ready), 64'd1);

    // 1: nominal frame, second pass is the one captured
    send_case1();
    chk("c1_busy", {62'd0, busy, s_ready}, 64'b10);
    wait_result("c1", 32'h0014_0000);
    chk("c1_err", 64'(err), 64'd0);
    handshake("c1");

    // 2: negative sum clamps to zero, single result
    send_beat(32'h0010_0000, 16'hFC00, 1'b0);
    send_beat(32'h0000_0000, 16'h0000, 1'b0);
    send_beat(32'h0000_0000, 16'h0000, 1'b1);
    wait_result("c2", 32'h0);
    handshake("c2");
    mv_seen = 0;
    for (int i = 0; i < 3 * PASS; i++) begin @(negedge clk); mv_seen += int'(m_valid); end
    chk("c2_mvalid_once", 64'(mv_seen), 64'd0);
    chk("c2_err", 64'(err), 64'd0);

    // 3: result held under back-pressure
    send_case1();
    wait_result("c3", 32'h0014_0000);
    held = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid && !s_ready && m_data == 32'h0014_0000) held++;
    end
    chk("c3_held", 64'(held), 64'd20);
    handshake("c3");

    // 4: short frame aborts with error, next frame still works
    send_beat(32'h0010_0000, 16'h0200, 1'b1);
    @(negedge clk);
    chk("c4_abort", {61'd0, err, busy, s_ready}, 64'b101);
    send_case1();
    wait_result("c4", 32'h0014_0000);
    handshake("c4");

    // 5: neuron stalls -> timeout error exactly after TIMEOUT cycles in ARM
    do_reset();
    nrn_en = 1'b0;
    send_case1();
    mv_seen = 0;
    for (int i = 0; i < TIMEOUT; i++) begin @(negedge clk); mv_seen += int'(m_valid); end
    chk("c5_before_tmo", {62'd0, err, busy}, 64'b01);
    @(negedge clk);
    chk("c5_tmo", {61'd0, err, busy, s_ready}, 64'b101);
    for (int i = 0; i < 10; i++) begin @(negedge clk); mv_seen += int'(m_valid); end
    chk("c5_no_result", 64'(mv_seen), 64'd0);
    nrn_en = 1'b1;

    // 6: asynchronous reset in WAIT, then a clean frame
    do_reset();
    send_case1();
    begin
      bit flushed = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (nrn_done) begin flushed = 1; break; end
      end
      chk("c6_flush_seen", 64'(flushed), 64'd1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("c6_async_ops", {nrn_in, nrn_weights[1], nrn_bias}, 64'd0);
    chk("c6_async_flags", {59'd0, s_ready, m_valid, busy, err, |m_data}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("c6_sready", 64'(s_ready), 64'd1);
    send_case1();
    wait_result("c6", 32'h0014_0000);
    chk("c6_err", 64'(err), 64'd0);
    handshake("c6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
